ps2_key_event: RTL and testbench
================================

// Module: ps2_key_event
// PURPOSE
//  Upstream stage of the cipher path. Sits between the PS/2 keyboard receiver and the plugboard/rotor chain.
//  Parses raw scan bytes (make, F0 break, E0 extended) into clean letter-press events.
//  Buffers the events in a small FIFO and hands them downstream with a valid/ready handshake.
//  Each accepted event drives exactly one rotor step and one cipher lookup.
// PARAMETERS
//  FIFO_DEPTH  4  event FIFO entries; power of 2, >=2; PTR_W = log2(FIFO_DEPTH) derived locally
// PORTS
//  clock       in   1   system clock (CLOCK_50 domain)
//  reset       in   1   asynchronous, active-high reset
//  scan_code   in   8   byte from the PS/2 receiver, already synchronous to clock
//  scan_valid  in   1   1-cycle strobe: scan_code is valid this cycle
//  ev_ready    in   1   downstream accepts the head event this cycle
//  ovf_clr     in   1   clears the overflow flag
//  ev_valid    out  1   FIFO not empty; head event presented
//  ev_code     out  5   head letter, binary A=0..Z=25
//  ev_onehot   out  26  head letter one-hot, bit0=A; all zero when !ev_valid
//  key_held    out  1   a letter key is currently down
//  held_code   out  5   letter currently held; 0 when !key_held
//  overflow    out  1   sticky: an event was dropped because the FIFO was full
// BEHAVIOUR
//  Reset values: ev_valid=0, ev_code=0, ev_onehot=0, key_held=0, held_code=0, overflow=0.
//   Reset also empties the FIFO and puts the FSM in IDLE. Reset mid-frame discards partial F0/E0 sequences.
//  Parser FSM; advances only on scan_valid:
//   IDLE:  F0 -> BRK; E0 -> EXT; letter make -> emit (see below), stay IDLE; other bytes ignored.
//   BRK:   letter==held_code with key_held -> key_held=0, held_code=0; any other byte ignored; -> IDLE.
//   EXT:   F0 -> EXTBRK; any other byte -> IDLE, no event.
//   EXTBRK: any byte -> IDLE, no event.
//  Emit rules:
//   - A letter make while !key_held, or with a code different from held_code, pushes an event.
//     It also sets key_held=1 and held_code=letter; the newest key wins.
//   - A make equal to held_code while key_held is a typematic repeat; see CONFIGURATION.
//  Latency: scan_valid in cycle N -> FIFO write at the end of N -> ev_valid/ev_code visible in cycle N+1.
//   key_held/held_code also update at the end of N.
//  Handshake: a pop occurs when ev_valid && ev_ready.
//   ev_code/ev_onehot hold stable while ev_valid && !ev_ready.
//  FIFO boundaries:
//   - Empty: ev_ready is ignored and no pop occurs.
//   - Full with push and no pop: the new event is dropped, the FIFO is unchanged, overflow=1.
//   - Full with push and pop in the same cycle: both succeed, no drop.
//   - Pointers wrap modulo FIFO_DEPTH. The count width is PTR_W+1, so full and empty are distinct.
//  overflow: set wins over ovf_clr when both occur in the same cycle; otherwise ovf_clr clears it.
// CONFIGURATION
//  KEY_AUTOREPEAT_EN defined: typematic repeats of the held key push an event each, so the rotors step per repeat.
//  KEY_AUTOREPEAT_EN undefined: repeats are silently suppressed; one event per physical press.
// STRUCTURE
//  enigma_pkg: ALPHA_N=26, LETTER_W=5, SCAN_BREAK=8'hF0, SCAN_EXT=8'hE0, parser state encodings,
//   and the 26 letter scan-code constants (A=1C ... Z=1A).
//  Sub-module ps2_letter_lookup (combinational): scan_code -> {is_letter, code[4:0]}.
//   Reused later by the display and Morse path.
//  FIFO storage is a register array inside this module; there is no separate FIFO module.
// TESTING
//  1. Send 1C with ev_ready=0 -> ev_valid=1 in the next cycle, ev_code=0, ev_onehot=26'h1, key_held=1, held_code=0.
//  2. Send 1C,1C,1C, then F0,1C -> one event only (macro off) or three events (macro on).
//     After the break: key_held=0.
//  3. Send E0,F0,1C, then E0,75 -> no events and key_held unchanged; the next 32 (B) yields ev_code=1.
//  4. Hold ev_ready=0 and send 5 distinct letters (depth 4) -> 4 events queued, the 5th dropped, overflow=1.
//     Then ovf_clr -> overflow=0, with the queued order A,B,C,D preserved.
//  5. Full FIFO with ev_ready=1 and a new make in the same cycle -> count stays 4, overflow stays 0,
//     and the new letter is last out.
//  6. Assert reset after F0 and mid-queue -> all outputs 0; the following 1C is treated as a make.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared constants for the keyboard-to-cipher path: alphabet size, PS/2 set-2 prefixes,
// parser state encodings and the 26 letter make codes.
// Pure declarations; no logic, no latency, no flow control.
package enigma_pkg;

    localparam int ALPHA_N  = 26;
    localparam int LETTER_W = 5;

    localparam logic [7:0] SCAN_BREAK = 8'hF0;
    localparam logic [7:0] SCAN_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BRK    = 2'd1,
        ST_EXT    = 2'd2,
        ST_EXTBRK = 2'd3
    } parse_state_t;

    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_B = 8'h32;
    localparam logic [7:0] SC_C = 8'h21;
    localparam logic [7:0] SC_D = 8'h23;
    localparam logic [7:0] SC_E = 8'h24;
    localparam logic [7:0] SC_F = 8'h2B;
    localparam logic [7:0] SC_G = 8'h34;
    localparam logic [7:0] SC_H = 8'h33;
    localparam logic [7:0] SC_I = 8'h43;
    localparam logic [7:0] SC_J = 8'h3B;
    localparam logic [7:0] SC_K = 8'h42;
    localparam logic [7:0] SC_L = 8'h4B;
    localparam logic [7:0] SC_M = 8'h3A;
    localparam logic [7:0] SC_N = 8'h31;
    localparam logic [7:0] SC_O = 8'h44;
    localparam logic [7:0] SC_P = 8'h4D;
    localparam logic [7:0] SC_Q = 8'h15;
    localparam logic [7:0] SC_R = 8'h2D;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_T = 8'h2C;
    localparam logic [7:0] SC_U = 8'h3C;
    localparam logic [7:0] SC_V = 8'h2A;
    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_X = 8'h22;
    localparam logic [7:0] SC_Y = 8'h35;
    localparam logic [7:0] SC_Z = 8'h1A;

endpackage

// File: rtl/ps2_letter_lookup.sv
// Maps a PS/2 set-2 make code to {is_letter, letter index A=0..Z=25}.
// Purely combinational, zero latency.
// No flow control; non-letter bytes give is_letter=0 and code=0.
module ps2_letter_lookup
    import enigma_pkg::*;
(
    input  logic [7:0]          scan_code,
    output logic                is_letter,
    output logic [LETTER_W-1:0] code
);

    // Table decode of the 26 letter make codes
    always_comb begin
        is_letter = 1'b1;
        code      = '0;
        case (scan_code)
            SC_A: code = 5'd0;
            SC_B: code = 5'd1;
            SC_C: code = 5'd2;
            SC_D: code = 5'd3;
            SC_E: code = 5'd4;
            SC_F: code = 5'd5;
            SC_G: code = 5'd6;
            SC_H: code = 5'd7;
            SC_I: code = 5'd8;
            SC_J: code = 5'd9;
            SC_K: code = 5'd10;
            SC_L: code = 5'd11;
            SC_M: code = 5'd12;
            SC_N: code = 5'd13;
            SC_O: code = 5'd14;
            SC_P: code = 5'd15;
            SC_Q: code = 5'd16;
            SC_R: code = 5'd17;
            SC_S: code = 5'd18;
            SC_T: code = 5'd19;
            SC_U: code = 5'd20;
            SC_V: code = 5'd21;
            SC_W: code = 5'd22;
            SC_X: code = 5'd23;
            SC_Y: code = 5'd24;
            SC_Z: code = 5'd25;
            default: is_letter = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_key_event.sv
// Parses PS/2 make/break/extended bytes into letter-press events queued in a small FIFO.
// Latency: scan byte in cycle N -> event visible on ev_valid/ev_code in N+1.
// Backpressure: ev_valid/ev_ready handshake; a push into a full FIFO without a pop is dropped and sets overflow.
// Build option KEY_AUTOREPEAT_EN: when defined, typematic repeats of the held key each push an event.
module ps2_key_event
    import enigma_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          scan_code,
    input  logic                scan_valid,
    input  logic                ev_ready,
    input  logic                ovf_clr,
    output logic                ev_valid,
    output logic [LETTER_W-1:0] ev_code,
    output logic [ALPHA_N-1:0]  ev_onehot,
    output logic                key_held,
    output logic [LETTER_W-1:0] held_code,
    output logic                overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    parse_state_t        state, state_nx;
    logic                is_letter;
    logic [LETTER_W-1:0] letter;
    logic                make_letter;
    logic                push;
    logic                release_key;

    logic [LETTER_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [PTR_W:0]      count;
    logic                full, pop, do_push, drop;

    ps2_letter_lookup u_lookup (
        .scan_code (scan_code),
        .is_letter (is_letter),
        .code      (letter)
    );

    // Parser state register; reset discards any half-received F0/E0 sequence
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Parser next state plus make/break decisions, evaluated only on a scan strobe
    always_comb begin
        state_nx    = state;
        make_letter = 1'b0;
        push        = 1'b0;
        release_key = 1'b0;
        if (scan_valid) begin
            case (state)
                ST_IDLE: begin
                    if (scan_code == SCAN_BREAK)      state_nx = ST_BRK;
                    else if (scan_code == SCAN_EXT)   state_nx = ST_EXT;
                    else if (is_letter) begin
                        make_letter = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                        push = 1'b1;
`else
                        // A repeat of the held key is typematic noise, not a new press
                        push = !key_held || (letter != held_code);
`endif
                    end
                end
                ST_BRK: begin
                    release_key = is_letter && key_held && (letter == held_code);
                    state_nx    = ST_IDLE;
                end
                ST_EXT:    state_nx = (scan_code == SCAN_BREAK) ? ST_EXTBRK : ST_IDLE;
                ST_EXTBRK: state_nx = ST_IDLE;
                default:   state_nx = ST_IDLE;
            endcase
        end
    end

    // Held-key tracker: newest make wins, only a break of that same key clears it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_held  <= 1'b0;
            held_code <= '0;
        end else if (make_letter) begin
            key_held  <= 1'b1;
            held_code <= letter;
        end else if (release_key) begin
            key_held  <= 1'b0;
            held_code <= '0;
        end
    end

    assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign ev_valid = (count != '0);
    assign pop     = ev_valid && ev_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign do_push = push && (!full || pop);
    assign drop    = push && full && !pop;

    // FIFO pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written, outputs are gated by ev_valid
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= letter;
    end

    // Sticky overflow; a new drop outranks a clear in the same cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset)        overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

    assign ev_code   = ev_valid ? mem[rd_ptr] : '0;
    assign ev_onehot = ev_valid ? ({{(ALPHA_N-1){1'b0}}, 1'b1} << ev_code) : '0;

endmodule

// File: tb/tb_ps2_key_event.sv
// Directed bench for ps2_key_event: parser sequences, typematic handling, FIFO limits, reset.
// Inputs change on the falling edge; outputs are compared on the falling edge.
// Expected values are hand-derived constants per scenario.
module tb_ps2_key_event;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  scan_code = 8'h00;
    logic        scan_valid = 1'b0;
    logic        ev_ready = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        ev_valid;
    logic [4:0]  ev_code;
    logic [25:0] ev_onehot;
    logic        key_held;
    logic [4:0]  held_code;
    logic        overflow;

    int vectors = 0;
    int miscompares = 0;

`ifdef KEY_AUTOREPEAT_EN
    localparam int REPEAT_EVENTS = 3;
`else
    localparam int REPEAT_EVENTS = 1;
`endif

    ps2_key_event #(.FIFO_DEPTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .ev_ready   (ev_ready),
        .ovf_clr    (ovf_clr),
        .ev_valid   (ev_valid),
        .ev_code    (ev_code),
        .ev_onehot  (ev_onehot),
        .key_held   (key_held),
        .held_code  (held_code),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        scan_code  = b;
        scan_valid = 1'b1;
        @(negedge clock);
        scan_valid = 1'b0;
    endtask

    task automatic do_pop();
        @(negedge clock);
        ev_ready = 1'b1;
        @(negedge clock);
        ev_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        vectors++; if (ev_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ev_valid got %b want 0", ev_valid); end
        vectors++; if (ev_code !== 5'd0) begin miscompares++; $display("FAIL reset_ev_code got %0d want 0", ev_code); end
        vectors++; if (ev_onehot !== 26'h0) begin miscompares++; $display("FAIL reset_onehot got %h want 0", ev_onehot); end
        vectors++; if (key_held !== 1'b0 || held_code !== 5'd0) begin miscompares++; $display("FAIL reset_held got %b/%0d want 0/0", key_held, held_code); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b want 0", overflow); end
    endtask

    task automatic test_single_make();
        send_byte(8'h1C);
        vectors++; if (ev_valid !== 1'b1) begin miscompares++; $display("FAIL make_ev_valid got %b want 1", ev_valid); end
        vectors++; if (ev_code !== 5'd0) begin miscompares++; $display("FAIL make_ev_code got %0d want 0", ev_code); end
        vectors++; if (ev_onehot !== 26'h1) begin miscompares++; $display("FAIL make_onehot got %h want 1", ev_onehot); end
        vectors++; if (key_held !== 1'b1 || held_code !== 5'd0) begin miscompares++; $display("FAIL make_held got %b/%0d want 1/0", key_held, held_code); end
        // head must stay put while not accepted
        repeat (3) @(negedge clock);
        vectors++; if (ev_valid !== 1'b1 || ev_code !== 5'd0) begin miscompares++; $display("FAIL make_stable got %b/%0d want 1/0", ev_valid, ev_code); end
        do_pop();
        vectors++; if (ev_valid !== 1'b0 || ev_onehot !== 26'h0) begin miscompares++; $display("FAIL make_popped got %b/%h want 0/0", ev_valid, ev_onehot); end
        send_byte(8'hF0);
        send_byte(8'h1C);
        vectors++; if (key_held !== 1'b0 || held_code !== 5'd0) begin miscompares++; $display("FAIL make_release got %b/%0d want 0/0", key_held, held_code); end
    endtask

    task automatic test_typematic();
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        vectors++; if (key_held !== 1'b0) begin miscompares++; $display("FAIL rep_release got %b want 0", key_held); end
        for (int i = 0; i < REPEAT_EVENTS; i++) begin
            vectors++; if (ev_valid !== 1'b1 || ev_code !== 5'd0) begin miscompares++; $display("FAIL rep_event%0d got %b/%0d want 1/0", i, ev_valid, ev_code); end
            do_pop();
        end
        vectors++; if (ev_valid !== 1'b0) begin miscompares++; $display("FAIL rep_extra got %b want 0", ev_valid); end
    endtask

    task automatic test_extended();
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h1C);
        send_byte(8'hE0);
        send_byte(8'h75);
        vectors++; if (ev_valid !== 1'b0) begin miscompares++; $display("FAIL ext_no_event got %b want 0", ev_valid); end
        vectors++; if (key_held !== 1'b0) begin miscompares++; $display("FAIL ext_held got %b want 0", key_held); end
        send_byte(8'h32);
        vectors++; if (ev_valid !== 1'b1 || ev_code !== 5'd1 || ev_onehot !== 26'h2) begin miscompares++; $display("FAIL ext_next_b got %b/%0d/%h want 1/1/2", ev_valid, ev_code, ev_onehot); end
        do_pop();
        send_byte(8'hF0);
        send_byte(8'h32);
        vectors++; if (key_held !== 1'b0) begin miscompares++; $display("FAIL ext_b_release got %b want 0", key_held); end
    endtask

    task automatic test_overflow();
        send_byte(8'h1C);
        send_byte(8'h32);
        send_byte(8'h21);
        send_byte(8'h23);
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_at_full got %b want 0", overflow); end
        send_byte(8'h24);
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set got %b want 1", overflow); end
        vectors++; if (held_code !== 5'd4) begin miscompares++; $display("FAIL ovf_held got %0d want 4", held_code); end
        @(negedge clock);
        ovf_clr = 1'b1;
        @(negedge clock);
        ovf_clr = 1'b0;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clr got %b want 0", overflow); end
        // drop and clear together: the drop wins
        @(negedge clock);
        scan_code = 8'h2B; scan_valid = 1'b1; ovf_clr = 1'b1;
        @(negedge clock);
        scan_valid = 1'b0; ovf_clr = 1'b0;
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set_wins got %b want 1", overflow); end
        @(negedge clock);
        ovf_clr = 1'b1;
        @(negedge clock);
        ovf_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (ev_valid !== 1'b1 || ev_code !== 5'(i)) begin miscompares++; $display("FAIL ovf_order%0d got %b/%0d want 1/%0d", i, ev_valid, ev_code, i); end
            do_pop();
        end
        vectors++; if (ev_valid !== 1'b0 || overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_drained got %b/%b want 0/0", ev_valid, overflow); end
    endtask

    task automatic test_full_push_pop();
        send_byte(8'h34);
        send_byte(8'h33);
        send_byte(8'h43);
        send_byte(8'h3B);
        @(negedge clock);
        scan_code = 8'h42; scan_valid = 1'b1; ev_ready = 1'b1;
        @(negedge clock);
        scan_valid = 1'b0; ev_ready = 1'b0;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fpp_overflow got %b want 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (ev_valid !== 1'b1 || ev_code !== 5'(7 + i)) begin miscompares++; $display("FAIL fpp_order%0d got %b/%0d want 1/%0d", i, ev_valid, ev_code, 7 + i); end
            do_pop();
        end
        vectors++; if (ev_valid !== 1'b0) begin miscompares++; $display("FAIL fpp_count got %b want 0", ev_valid); end
    endtask

    task automatic test_reset_midstream();
        send_byte(8'h4B);
        send_byte(8'h44);
        send_byte(8'hF0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        vectors++; if (ev_valid !== 1'b0 || ev_code !== 5'd0 || ev_onehot !== 26'h0) begin miscompares++; $display("FAIL rst_mid_fifo got %b/%0d/%h want 0/0/0", ev_valid, ev_code, ev_onehot); end
        vectors++; if (key_held !== 1'b0 || held_code !== 5'd0 || overflow !== 1'b0) begin miscompares++; $display("FAIL rst_mid_held got %b/%0d/%b want 0/0/0", key_held, held_code, overflow); end
        send_byte(8'h1C);
        vectors++; if (ev_valid !== 1'b1 || ev_code !== 5'd0 || key_held !== 1'b1) begin miscompares++; $display("FAIL rst_mid_make got %b/%0d/%b want 1/0/1", ev_valid, ev_code, key_held); end
    endtask

    initial begin
        test_reset();
        test_single_make();
        test_typematic();
        test_extended();
        test_overflow();
        test_full_push_pop();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
